movement_scheduler: RTL

MOVEMENT_SCHEDULER -- requirements
Module: movement_scheduler

---
 rtl/movement_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/movement_scheduler.sv
// Movement scheduler: sequences the sprite datapath through one crosshair
// slot and an optional bird slot per display frame. Each slot erases the
// sprite, applies the latched move requests one step at a time, then
// redraws. A watchdog bounds each wait on the datapath, and frame ticks
// that arrive while a slot is running are queued one deep.
module movement_scheduler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       p_left,
  input  logic       p_right,
  input  logic       p_up,
  input  logic       p_down,
  input  logic       b_left,
  input  logic       b_right,
  input  logic       b_up,
  input  logic       b_down,
  input  logic       bird_active,
  input  logic       enable,
  output logic [3:0] control,
  output logic       PorB,
  output logic       busy,
  output logic       overrun,
  output logic       timeout
);

  // State encodings are the datapath control codes themselves, so the
  // control output is the state register with no decode in between.
  typedef enum logic [3:0] {
    S_HOLD    = 4'b0000,
    S_CLEAR   = 4'b0001,
    S_RIGHT   = 4'b0010,
    S_LEFT    = 4'b0011,
    S_PREHOLD = 4'b0100,
    S_DRAW    = 4'b0101,
    S_DOWN    = 4'b0110,
    S_UP      = 4'b0111
  } state_t;

  localparam logic [7:0] WDOG_LIMIT = 8'hFF;

  state_t     state;
  logic [3:0] move;      // latched requests {left, right, down, up}
  logic [7:0] wdog;      // cycles spent in the current CLEAR/DRAW
  logic       pending;   // one frame tick queued while busy

  logic [3:0] move_eff;  // requests after opposing pairs cancel
  logic       wd_expired;
  logic       wait_done;

  // Opposing requests cancel each other so the sprite does not jitter.
  assign move_eff = {move[3] & ~move[2],
                     move[2] & ~move[3],
                     move[1] & ~move[0],
                     move[0] & ~move[1]};

  // The first cycle of CLEAR/DRAW (wdog==0) sees the previous sprite's
  // stale enable, so only later cycles may accept it.
  assign wd_expired = (wdog == WDOG_LIMIT);
  assign wait_done  = ((wdog != 8'd0) && enable) || wd_expired;

  assign control = state;
  assign busy    = (state != S_HOLD);

  // Pick the next move state at or after the allowed position in the fixed
  // LEFT, RIGHT, DOWN, UP order; fall through to DRAW when none remain.
  function automatic state_t next_move(input logic [3:0] req,
                                       input logic [3:0] allow);
    logic [3:0] m;
    m = req & allow;
    if (m[3])      return S_LEFT;
    else if (m[2]) return S_RIGHT;
    else if (m[1]) return S_DOWN;
    else if (m[0]) return S_UP;
    else           return S_DRAW;
  endfunction

  // Slot sequencer, tick queue, watchdog and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_HOLD;
      PorB    <= 1'b0;
      move    <= 4'b0000;
      wdog    <= 8'd0;
      pending <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      wdog <= 8'd0;

      if (frame_tick && busy) begin
        if (pending) overrun <= 1'b1;
        pending <= 1'b1;
      end

      case (state)
        S_HOLD: begin
          if (frame_tick || pending) begin
            state   <= S_PREHOLD;
            PorB    <= 1'b0;
            // A fresh tick landing together with a queued one stays queued.
            pending <= pending && frame_tick;
          end
        end

        S_PREHOLD: begin
          move  <= PorB ? {b_left, b_right, b_down, b_up}
                        : {p_left, p_right, p_down, p_up};
          state <= S_CLEAR;
        end

        S_CLEAR: begin
          if (wait_done) begin
            state <= next_move(move_eff, 4'b1111);
            if (wd_expired && !enable) timeout <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end

        S_LEFT:  state <= next_move(move_eff, 4'b0111);
        S_RIGHT: state <= next_move(move_eff, 4'b0011);
        S_DOWN:  state <= next_move(move_eff, 4'b0001);
        S_UP:    state <= S_DRAW;

        S_DRAW: begin
          if (wait_done) begin
            if (wd_expired && !enable) timeout <= 1'b1;
            if (!PorB && bird_active) begin
              state <= S_PREHOLD;
              PorB  <= 1'b1;
            end else begin
              state <= S_HOLD;
            end
          end else begin
            wdog <= wdog + 8'd1;
          end
        end

        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
